// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and constants shared by the multi-cycle ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011,
    OP_SHL = 4'b0100, OP_SUB = 4'b0110, OP_MUL = 4'b0111, OP_EQ  = 4'b1000,
    OP_NE  = 4'b1001, OP_LTU = 4'b1010, OP_GEU = 4'b1011, OP_SHR = 4'b1100,
    OP_SRA = 4'b1110, OP_DIV = 4'b1111
  } op_t;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  localparam int MAX_WIDTH = 1024;
  localparam logic [MAX_WIDTH-1:0] DIV0_ONES = '1;
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: restoring unsigned divider, one quotient bit per clock
module alu_div_iter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] rem, quo, div, src_rem, src_quo, src_div, rem_nx, quo_nx;
  logic [WIDTH:0] shifted, diff;
  logic [CW-1:0] cnt;
  // One restoring step; the start cycle feeds the fresh operands so it performs the first bit
  always_comb begin
    src_rem = start ? '0 : rem;
    src_quo = start ? a : quo;
    src_div = start ? b : div;
    shifted = {src_rem, src_quo[WIDTH-1]};
    diff = shifted - {1'b0, src_div};
    rem_nx = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx = {src_quo[WIDTH-2:0], !diff[WIDTH]};
  end
  // Iteration state; done is raised after the last bit and clears busy on the following edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      div <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem <= rem_nx;
      quo <= quo_nx;
      div <= b;
      cnt <= CW'(WIDTH - 1);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy && cnt != '0) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt - 1'b1;
      done <= cnt == CW'(1);
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
    end
  assign quotient = quo;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with single-cycle ops and an iterative divider
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             div_by_zero
);
  state_t state, state_nx;
  logic [WIDTH-1:0] alu_out, quotient;
  logic fire, is_div, b_big, div_start, div_busy, div_done;
  assign in_ready = state == IDLE;
  assign out_valid = state == HOLD;
  assign zero = ALUResult == '0;
  assign fire = in_valid && in_ready;
  assign is_div = operation == OP_DIV;
  assign b_big = |B[WIDTH-1:SHW];
  assign div_start = fire && is_div && B != '0 && !div_busy;
  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(div_start),
    .a(A),
    .b(B),
    .busy(div_busy),
    .done(div_done),
    .quotient(quotient)
  );
  // Single-cycle operations; anything unlisted (including div) yields zero here
  always_comb begin
    alu_out = '0;
    case (operation)
      OP_ADD:  alu_out = A + B;
      OP_SUB:  alu_out = A - B;
      OP_MUL:  alu_out = A * B;
      OP_SHL:  alu_out = b_big ? '0 : A << B[SHW-1:0];
      OP_SHR:  alu_out = b_big ? '0 : A >> B[SHW-1:0];
      OP_SRA:  alu_out = b_big ? {WIDTH{A[WIDTH-1]}} : $unsigned($signed(A) >>> B[SHW-1:0]);
      OP_AND:  alu_out = A & B;
      OP_OR:   alu_out = A | B;
      OP_XOR:  alu_out = A ^ B;
      OP_EQ:   alu_out = WIDTH'(A == B);
      OP_NE:   alu_out = WIDTH'(A != B);
      OP_LTU:  alu_out = WIDTH'(A < B);
      OP_GEU:  alu_out = WIDTH'(A >= B);
      default: alu_out = '0;
    endcase
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: non-div and div-by-zero go straight to HOLD, real divides wait in BUSY
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && fire) ? (div_start ? BUSY : HOLD) :
               (state == BUSY && div_done) ? HOLD :
               (state == HOLD && out_ready) ? IDLE : state;
  end
  // Result register: loaded at the handshake, or with the quotient when the divider finishes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ALUResult <= '0;
      div_by_zero <= 1'b0;
    end else if (fire && !div_start) begin
      ALUResult <= is_div ? DIV0_ONES[WIDTH-1:0] : alu_out;
      div_by_zero <= is_div;
    end else if (state == BUSY && div_done) begin
      ALUResult <= quotient;
      div_by_zero <= 1'b0;
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against an arithmetic model
module tb_alu_mc;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] operation = 4'd0;
  logic [31:0] A = '0, B = '0;
  logic in_ready, out_valid, zero, div_by_zero;
  logic [31:0] ALUResult;
  int checks = 0, failures = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .zero(zero),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return a * b;
      4'b1111: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b0100: return (b >= 32) ? 32'd0 : a << b;
      4'b1100: return (b >= 32) ? 32'd0 : a >> b;
      4'b1110: return $unsigned($signed(a) >>> ((b >= 32) ? 32'd31 : b));
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      4'b1001: return (a != b) ? 32'd1 : 32'd0;
      4'b1010: return (a < b) ? 32'd1 : 32'd0;
      4'b1011: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request with out_ready high and verify latency, result, flags and return to IDLE
  task automatic run_op(string tag, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] exp;
    int n, lat;
    logic rdy;
    exp = model(op, a, b);
    lat = (op == 4'b1111 && b != 0) ? 32 : 0;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    operation = op; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    A = $urandom; B = $urandom; operation = 4'($urandom);
    n = 0; rdy = 1'b0;
    while (!out_valid && n < 100) begin
      rdy |= in_ready;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, n, lat);
    check({tag, "_ready_busy"}, {31'd0, rdy}, 32'd0);
    check({tag, "_result"}, ALUResult, exp);
    check({tag, "_zero"}, {31'd0, zero}, (exp == 0) ? 32'd1 : 32'd0);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, (op == 4'b1111 && b == 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp, ra, rb;
    logic [3:0] rop;
    logic seen;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    run_op("add_5_7", 4'b0010, 32'd5, 32'd7);
    run_op("div_100_7", 4'b1111, 32'd100, 32'd7);
    run_op("div_by_0", 4'b1111, 32'h1234, 32'd0);
    run_op("sra_4", 4'b1110, 32'h8000_0000, 32'd4);
    run_op("shl_40", 4'b0100, 32'h8000_0000, 32'd40);
    run_op("shr_32", 4'b1100, 32'hFFFF_FFFF, 32'd32);
    run_op("sra_40", 4'b1110, 32'h8000_0001, 32'd40);
    run_op("sub_wrap", 4'b0110, 32'd3, 32'd5);
    run_op("div_max", 4'b1111, 32'hFFFF_FFFF, 32'd1);
    run_op("bad_op", 4'b0101, 32'd9, 32'd9);

    // Result held with out_ready low while further requests are offered
    operation = 4'b0011; A = 32'hA5A5_0F0F; B = 32'h0F0F_FFFF; in_valid = 1'b1; out_ready = 1'b0;
    exp = model(4'b0011, 32'hA5A5_0F0F, 32'h0F0F_FFFF);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; operation = 4'b0010; A = $urandom; B = $urandom;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", ALUResult, exp);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("hold_valid_end", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("hold_release", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("hold_no_queue", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a divide abandons it
    operation = 4'b1111; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", ALUResult, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("mid_rst_no_result", {31'd0, seen}, 32'd0);

    // Randomized traffic, biased toward shift boundaries, zero divisors and equal operands
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) :
           ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      ra = ($urandom_range(0, 4) == 0) ? rb : $urandom;
      run_op("rand", rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
